// File: rtl/mxint8_block_dequant.sv
// MXINT8 block -> float32 stream: captures one scaled block, emits one float32 per beat.
// Define MXINT8_DEQUANT_SUBNORMAL_EN to emit exact subnormals instead of flushing to signed zero.
module mxint8_block_dequant #(
    parameter int BLOCK_SIZE = 32,
    parameter int ELEM_W     = 8,
    parameter int SCALE_W    = 8,
    localparam int IW        = $clog2(BLOCK_SIZE)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [SCALE_W-1:0] i_scale,
    input  logic [ELEM_W-1:0] i_elements [BLOCK_SIZE-1:0],
    output logic              o_valid,
    input  logic              i_ready,
    output logic [31:0]       o_float32,
    output logic [IW-1:0]     o_index,
    output logic              o_last
);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [SCALE_W-1:0]  scale_q;
    logic [ELEM_W-1:0]   elem_q [BLOCK_SIZE-1:0];
    logic                load;

    // Element is 1.6 fixed point, so value = q * 2^(X-127-6).
    function automatic logic [31:0] dequant(input logic [7:0] q, input logic [7:0] x);
        logic             s;
        logic [7:0]       mag;
        logic [2:0]       p;
        logic signed [9:0] e;
        logic [6:0]       below;
`ifdef MXINT8_DEQUANT_SUBNORMAL_EN
        logic [22:0]      frac;
`endif
        s   = q[7];
        mag = s ? 8'(8'd0 - q) : q;
        p   = 3'd0;
        for (int i = 0; i < 8; i++)
            if (mag[i]) p = 3'(i);
        e     = $signed({2'b00, x}) + $signed({7'b0, p}) - 10'sd6;
        below = 7'(mag << (3'd7 - p));
`ifdef MXINT8_DEQUANT_SUBNORMAL_EN
        // Only reached with X <= 6, so x[2:0] is the whole scale.
        frac  = 23'(mag) << (5'd16 + {2'b00, x[2:0]});
`endif
        if (x == 8'hFF)          dequant = 32'h7FC0_0000;
        else if (q == 8'h00)     dequant = 32'h0000_0000;
        else if (e > 10'sd254)   dequant = {s, 31'h7F7F_FFFF};
        else if (e > 10'sd0)     dequant = {s, e[7:0], below, 16'h0000};
        else
`ifdef MXINT8_DEQUANT_SUBNORMAL_EN
                                 dequant = {s, 8'h00, frac};
`else
                                 dequant = {s, 31'b0};
`endif
    endfunction

    assign o_valid   = (state_q == STREAM);
    assign o_index   = idx_q;
    assign o_last    = o_valid && (idx_q == IW'(BLOCK_SIZE - 1));
    // Ready on the final accepted beat gives zero-bubble back-to-back blocks.
    assign o_ready   = (state_q == IDLE) || (o_valid && i_ready && o_last);
    assign load      = i_valid && o_ready;
    assign o_float32 = dequant(8'(elem_q[idx_q]), 8'(scale_q));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    state_d = STREAM;
                    idx_d   = '0;
                end
            end
            STREAM: begin
                if (i_ready) begin
                    if (o_last) begin
                        state_d = i_valid ? STREAM : IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            scale_q <= '0;
            for (int i = 0; i < BLOCK_SIZE; i++) elem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (load) begin
                scale_q <= i_scale;
                elem_q  <= i_elements;
            end
        end
    end

endmodule

// File: tb/tb_mxint8_block_dequant.sv
// Directed-vector bench for mxint8_block_dequant: table of block patterns plus flow-control/reset sequence.
module tb_mxint8_block_dequant;

    localparam int BS = 32;

    logic        i_clk, i_rst_n, i_valid, i_ready;
    logic        o_ready, o_valid, o_last;
    logic [7:0]  i_scale;
    logic [7:0]  i_elements [BS-1:0];
    logic [31:0] o_float32;
    logic [4:0]  o_index;

    int n_vec = 0;
    int n_bad = 0;

    mxint8_block_dequant dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_scale(i_scale), .i_elements(i_elements), .o_valid(o_valid), .i_ready(i_ready),
        .o_float32(o_float32), .o_index(o_index), .o_last(o_last)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [7:0]       scale;
        logic [3:0][7:0]  q;
        logic [3:0][31:0] exp;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load_pattern(input logic [7:0] sc, input logic [3:0][7:0] q);
        i_scale = sc;
        for (int i = 0; i < BS; i++) i_elements[i] = q[i % 4];
    endtask

    initial begin
        // Element i of each block is q[i%4], expected float exp[i%4].
        tbl[0] = '{8'h7F, {8'h40, 8'h40, 8'h40, 8'h40},
                   {32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000}};
        tbl[1] = '{8'h7F, {8'h01, 8'h80, 8'h00, 8'hC0},
                   {32'h3C800000, 32'hC0000000, 32'h00000000, 32'hBF800000}};
        tbl[2] = '{8'hFF, {8'h7F, 8'h80, 8'h40, 8'h00},
                   {32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000}};
        tbl[3] = '{8'hFE, {8'hFF, 8'h01, 8'h7F, 8'h80},
                   {32'hFC000000, 32'h7C000000, 32'h7F7E0000, 32'hFF7FFFFF}};
`ifdef MXINT8_DEQUANT_SUBNORMAL_EN
        tbl[4] = '{8'h01, {8'h00, 8'h40, 8'hFF, 8'h01},
                   {32'h00000000, 32'h00800000, 32'h80020000, 32'h00020000}};
        tbl[6] = '{8'h02, {8'h00, 8'h01, 8'h90, 8'h10},
                   {32'h00000000, 32'h00040000, 32'h81600000, 32'h00400000}};
`else
        tbl[4] = '{8'h01, {8'h00, 8'h40, 8'hFF, 8'h01},
                   {32'h00000000, 32'h00800000, 32'h80000000, 32'h00000000}};
        tbl[6] = '{8'h02, {8'h00, 8'h01, 8'h90, 8'h10},
                   {32'h00000000, 32'h00000000, 32'h81600000, 32'h00000000}};
`endif
        tbl[5] = '{8'h86, {8'h7E, 8'h03, 8'hE0, 8'h20},
                   {32'h437C0000, 32'h40C00000, 32'hC2800000, 32'h42800000}};

        i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        load_pattern(8'h00, 32'h0);
        #12;
        chk("reset o_valid", 32'(o_valid), 32'd0);
        chk("reset o_ready", 32'(o_ready), 32'd1);
        chk("reset o_index", 32'(o_index), 32'd0);
        chk("reset o_last",  32'(o_last),  32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_ready = 1'b1;

        for (int r = 0; r < 7; r++) begin
            @(negedge i_clk);
            load_pattern(tbl[r].scale, tbl[r].q);
            i_valid = 1'b1;
            chk($sformatf("row%0d accept ready", r), 32'(o_ready), 32'd1);
            @(negedge i_clk);
            i_valid = 1'b0;
            for (int b = 0; b < BS; b++) begin
                chk($sformatf("row%0d beat%0d valid", r, b), 32'(o_valid), 32'd1);
                chk($sformatf("row%0d beat%0d float", r, b), o_float32, tbl[r].exp[b % 4]);
                chk($sformatf("row%0d beat%0d index", r, b), 32'(o_index), 32'(b));
                chk($sformatf("row%0d beat%0d last", r, b), 32'(o_last), 32'(b == BS - 1));
                @(negedge i_clk);
            end
            chk($sformatf("row%0d idle after block", r), 32'(o_valid), 32'd0);
        end

        // Backpressure at index 5, back-to-back second block, reset mid-stream.
        @(negedge i_clk);
        load_pattern(tbl[5].scale, tbl[5].q);
        i_valid = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (5) @(negedge i_clk);
        chk("stall entry index", 32'(o_index), 32'd5);
        i_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            chk($sformatf("stall%0d valid", k), 32'(o_valid), 32'd1);
            chk($sformatf("stall%0d index", k), 32'(o_index), 32'd5);
            chk($sformatf("stall%0d float", k), o_float32, 32'hC2800000);
            chk($sformatf("stall%0d last", k), 32'(o_last), 32'd0);
            chk($sformatf("stall%0d ready", k), 32'(o_ready), 32'd0);
        end
        i_ready = 1'b1;
        load_pattern(tbl[0].scale, tbl[0].q);
        i_valid = 1'b1;
        for (int b = 5; b < BS; b++) begin
            chk($sformatf("b2b beat%0d index", b), 32'(o_index), 32'(b));
            chk($sformatf("b2b beat%0d ready", b), 32'(o_ready), 32'(b == BS - 1));
            chk($sformatf("b2b beat%0d float", b), o_float32, tbl[5].exp[b % 4]);
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        chk("b2b next valid", 32'(o_valid), 32'd1);
        chk("b2b next index", 32'(o_index), 32'd0);
        chk("b2b next float", o_float32, 32'h3F800000);
        repeat (10) @(negedge i_clk);
        chk("pre-reset index", 32'(o_index), 32'd10);
        i_rst_n = 1'b0;
        #1;
        chk("midreset o_valid", 32'(o_valid), 32'd0);
        chk("midreset o_ready", 32'(o_ready), 32'd1);
        chk("midreset o_index", 32'(o_index), 32'd0);
        chk("midreset o_last",  32'(o_last),  32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("post-reset idle", 32'(o_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
